// File: rtl/vga_text_pkg.sv
// Shared constants, FSM state codes and address packing for the VGA text console.
package vga_text_pkg;

  localparam int ROW_BITS  = 5;
  localparam int COL_BITS  = 7;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int COLS      = 80;
  localparam int ROWS      = 30;

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] ROW_END  = ROW_BITS'(ROWS);

  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_LF    = 7'h0A;
  localparam logic [6:0] ASCII_FF    = 7'h0C;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_DEL   = 7'h7F;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLR_ROW = 2'd1;
  localparam logic [1:0] CLR_SCR = 2'd2;

  function automatic logic [ADDR_BITS-1:0] pack_addr(input logic [ROW_BITS-1:0] row,
                                                     input logic [COL_BITS-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor position on the text grid; advance/newline/CR/backspace/home with wrap detection.
module text_cursor
  import vga_text_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  logic                newline,
  input  logic                carriage,
  input  logic                backspace,
  input  logic                home,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                wrap_to_top
);

  logic at_last_col;
  logic at_last_row;
  logic line_feed;

  assign at_last_col = (col == LAST_COL);
  assign at_last_row = (row == LAST_ROW);
  // Printing into the last column implies a newline as well.
  assign line_feed   = newline | (advance & at_last_col);
  assign wrap_to_top = line_feed & at_last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else begin
      if (advance) begin
        col <= at_last_col ? '0 : col + 7'd1;
      end else if (carriage) begin
        col <= '0;
      end else if (backspace && col != '0) begin
        col <= col - 7'd1;
      end
      if (line_feed) begin
        row <= at_last_row ? '0 : row + 5'd1;
      end
    end
  end

endmodule

// File: rtl/vga_text_console.sv
// Byte-stream front end: turns ASCII bytes into character-memory writes and runs row/screen clears.
module vga_text_console
  import vga_text_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_char,
  output logic                 in_ready,
  output logic                 char_we,
  output logic [ADDR_BITS-1:0] char_addr,
  output logic [31:0]          char_value,
  output logic [COL_BITS-1:0]  cur_col,
  output logic [ROW_BITS-1:0]  cur_row,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  logic [1:0]          state;
  logic [COL_BITS-1:0] clr_col;
  logic [ROW_BITS-1:0] clr_row;
  logic [6:0]          ch;
  logic                accept;
  logic                is_print, is_cr, is_lf, is_bs, is_ff;
  logic                wrap_to_top;
  logic                clr_done;
  logic                unused_bit7;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready is
  // high only in IDLE, and the producer holds in_char stable until the transfer happens.
  assign in_ready    = (state == IDLE);
  assign busy        = ~in_ready;
  assign dbg_state   = state;
  assign accept      = in_valid & in_ready;
  assign ch          = in_char[6:0];
  assign unused_bit7 = in_char[7];

  assign is_print = (ch >= ASCII_SPACE) && (ch != ASCII_DEL);
  assign is_cr    = (ch == ASCII_CR);
  assign is_lf    = (ch == ASCII_LF);
  assign is_bs    = (ch == ASCII_BS);
  assign is_ff    = (ch == ASCII_FF);

  // The counter runs one step past the last cell; that extra cycle lets the final write retire.
  assign clr_done = (state == CLR_ROW) ? (clr_row == 5'd1) : (clr_row == ROW_END);

  text_cursor u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (accept & is_print),
    .newline     (accept & is_lf),
    .carriage    (accept & is_cr),
    .backspace   (accept & is_bs),
    .home        (accept & is_ff),
    .col         (cur_col),
    .row         (cur_row),
    .wrap_to_top (wrap_to_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_col    <= '0;
      clr_row    <= '0;
      char_we    <= 1'b0;
      char_addr  <= '0;
      char_value <= '0;
    end else begin
      char_we <= 1'b0;
      case (state)
        IDLE: begin
          clr_row <= '0;
          // LF/FF issue cell 0 immediately, so their clear resumes at column 1.
          clr_col <= (accept && (is_lf || is_ff)) ? 7'd1 : 7'd0;
          if (accept) begin
            if (is_print) begin
              char_we    <= 1'b1;
              char_addr  <= pack_addr(cur_row, cur_col);
              char_value <= {25'd0, ch};
              if (wrap_to_top) state <= CLR_ROW;
            end else if (is_lf && wrap_to_top) begin
              char_we    <= 1'b1;
              char_addr  <= pack_addr('0, '0);
              char_value <= {25'd0, ASCII_SPACE};
              state      <= CLR_ROW;
            end else if (is_bs && cur_col != '0) begin
              char_we    <= 1'b1;
              char_addr  <= pack_addr(cur_row, cur_col - 7'd1);
              char_value <= {25'd0, ASCII_SPACE};
            end else if (is_ff) begin
              char_we    <= 1'b1;
              char_addr  <= pack_addr('0, '0);
              char_value <= {25'd0, ASCII_SPACE};
              state      <= CLR_SCR;
            end
          end
        end
        CLR_ROW, CLR_SCR: begin
          if (clr_done) begin
            state <= IDLE;
          end else begin
            char_we    <= 1'b1;
            char_addr  <= pack_addr(clr_row, clr_col);
            char_value <= {25'd0, ASCII_SPACE};
            if (clr_col == LAST_COL) begin
              clr_col <= '0;
              clr_row <= clr_row + 5'd1;
            end else begin
              clr_col <= clr_col + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: directed literal cases plus random bytes against a grid model.
module tb_vga_text_console;

  localparam int W = 19;  // {addr[11:0], ascii[6:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic        char_we;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;
  logic [1:0]  dbg_state;

  vga_text_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .char_we    (char_we),
    .char_addr  (char_addr),
    .char_value (char_value),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [43:0]  wr_log[$];
  int m_col = 0;
  int m_row = 0;
  int busy_left = 0;
  logic [W-1:0] e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void push_w(input int r, input int c, input int ascii);
    exp_q.push_back({12'(r * 128 + c), 7'(ascii)});
  endfunction

  function automatic void m_newline();
    if (m_row < 29) begin
      m_row++;
    end else begin
      m_row = 0;
      for (int c = 0; c < 80; c++) push_w(0, c, 32);
      busy_left = exp_q.size();
    end
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    int ch;
    ch = int'(b & 8'h7F);
    if (ch >= 32 && ch <= 126) begin
      push_w(m_row, m_col, ch);
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        m_newline();
      end
    end else if (ch == 13) begin
      m_col = 0;
    end else if (ch == 10) begin
      m_newline();
    end else if (ch == 8) begin
      if (m_col > 0) begin
        m_col--;
        push_w(m_row, m_col, 32);
      end
    end else if (ch == 12) begin
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 80; c++) push_w(r, c, 32);
      m_col = 0;
      m_row = 0;
      busy_left = exp_q.size();
    end
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (busy_left == 0) begin
        if (in_valid) m_accept(in_char);
      end else begin
        busy_left--;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (char_we) wr_log.push_back({char_addr, char_value});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_strobe", char_we, 1);
        chk("write_addr", char_addr, e[18:7]);
        chk("write_value", char_value, {25'd0, e[6:0]});
      end else begin
        chk("no_write", char_we, 0);
      end
      chk("in_ready", in_ready, busy_left == 0);
      chk("busy", busy, busy_left != 0);
      chk("cur_col", cur_col, m_col);
      chk("cur_row", cur_row, m_row);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    busy_left = 0;
    m_col = 0;
    m_row = 0;
    #1;
    chk("rst_char_we", char_we, 0);
    chk("rst_char_addr", char_addr, 0);
    chk("rst_char_value", char_value, 0);
    chk("rst_cur_col", cur_col, 0);
    chk("rst_cur_row", cur_row, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_we", char_we, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    wr_log.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char = b;
    while (!in_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int badcnt;
    int ff_count;
    int r;
    logic [7:0] b;

    do_reset();

    // Single printable character.
    send(8'h41);
    settle();
    chk("A_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("A_write", wr_log[0], {12'h000, 32'h0000_0041});
    chk("A_col", cur_col, 1);
    chk("A_row", cur_row, 0);
    chk("A_ready", in_ready, 1);

    // "Hi" CR LF "x"
    do_reset();
    send(8'h48); send(8'h69); send(8'h0D); send(8'h0A); send(8'h78);
    settle();
    chk("Hi_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("Hi_w0", wr_log[0], {12'h000, 32'h48});
      chk("Hi_w1", wr_log[1], {12'h001, 32'h69});
      chk("Hi_w2", wr_log[2], {12'h080, 32'h78});
    end
    chk("Hi_col", cur_col, 1);
    chk("Hi_row", cur_row, 1);

    // Backspace at column 0, then "ab" BS.
    do_reset();
    send(8'h08);
    settle();
    chk("bs0_count", wr_log.size(), 0);
    chk("bs0_col", cur_col, 0);
    chk("bs0_row", cur_row, 0);
    send(8'h61); send(8'h62); send(8'h08);
    settle();
    chk("bs_count", wr_log.size(), 3);
    if (wr_log.size() == 3) chk("bs_w2", wr_log[2], {12'h001, 32'h20});
    chk("bs_col", cur_col, 1);
    chk("bs_row", cur_row, 0);

    // LF on row 29 wraps and blanks row 0; a held byte goes in afterwards.
    do_reset();
    repeat (29) send(8'h0A);
    chk("row29", cur_row, 29);
    wr_log.delete();
    send(8'h0A);
    in_valid = 1'b1;
    in_char = 8'h51;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (in_ready || cnt >= 200) break;
      cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    settle();
    chk("lf_ready_low_cycles", cnt, 80);
    chk("lf_log_count", wr_log.size(), 81);
    badcnt = 0;
    if (wr_log.size() == 81)
      for (int i = 0; i < 80; i++)
        if (wr_log[i] !== {12'(i), 32'h20}) badcnt++;
    chk("lf_clear_entries_bad", badcnt, 0);
    if (wr_log.size() == 81) chk("lf_held_byte", wr_log[80], {12'h000, 32'h51});
    chk("lf_col", cur_col, 1);
    chk("lf_row", cur_row, 0);

    // Form feed clears the whole screen.
    do_reset();
    send(8'h6B);
    send(8'h0C);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cnt >= 3000) break;
      cnt++;
    end
    settle();
    chk("ff_busy_cycles", cnt, 2400);
    chk("ff_log_count", wr_log.size(), 2401);
    badcnt = 0;
    if (wr_log.size() == 2401)
      for (int i = 0; i < 2400; i++) begin
        if (wr_log[i+1][38:32] >= 7'd80) badcnt++;
        if (wr_log[i+1] !== {12'((i / 80) * 128 + (i % 80)), 32'h20}) badcnt++;
      end
    chk("ff_entries_bad", badcnt, 0);
    chk("ff_col", cur_col, 0);
    chk("ff_row", cur_row, 0);

    // Reset halfway through a screen clear.
    send(8'h0C);
    repeat (1200) @(negedge clk);
    chk("midff_busy", busy, 1);
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    chk("midff_no_writes", wr_log.size(), 0);
    send(8'h5A);
    settle();
    chk("Z_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("Z_write", wr_log[0], {12'h000, 32'h5A});

    // Randomized byte stream.
    do_reset();
    ff_count = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'($urandom_range(32, 126)) | 8'($urandom_range(0, 1) << 7);
      else if (r < 80) b = 8'h0A;
      else if (r < 85) b = 8'h0D;
      else if (r < 91) b = 8'h08;
      else if (r < 98) b = ($urandom_range(0, 4) == 0) ? 8'h7F : 8'($urandom_range(0, 31));
      else if (ff_count < 2) begin
        b = 8'h0C;
        ff_count++;
      end else b = 8'h41;
      send(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    cnt = 0;
    while ((busy_left != 0 || exp_q.size() != 0) && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain_timeout", cnt >= 5000, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_console.md
# vga_text_console

Character-stream front end for the VGA text controller. It accepts ASCII bytes over a valid/ready handshake and keeps a cursor on the 80x30 text grid. It turns printable characters and control codes into single-cycle character-memory writes (`char_we`/`char_addr`/`char_value`), which connect directly to the VGA controller's character-write port. Sits between the processor I/O register (or UART receive path) and the VGA controller, in the data clock domain.

## Interface
- `COLS`, 80, visible columns per row
- `ROWS`, 30, visible rows
- `ROW_BITS`, 5, row index width; `COL_BITS`, 7, column index width (address = {row, col})
- `clk`  in  1  data-domain clock (same clock as the controller's data port)
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  byte present on `in_char`
- `in_char`  in  8  ASCII byte; bit 7 is ignored
- `in_ready`  out  1  block can accept a byte this cycle
- `char_we`  out  1  one-cycle write strobe to character memory
- `char_addr`  out  12  write address {row[4:0], col[6:0]}
- `char_value`  out  32  {24'd0, 1'b0, ascii[6:0]}; upper bits zero select the default colours
- `cur_col`  out  7  current cursor column
- `cur_row`  out  5  current cursor row
- `busy`  out  1  clear sequence in progress

## Operation
- Handshake: a byte is accepted on a rising `clk` edge with `in_valid && in_ready`. `in_ready` = (state == IDLE), combinational from the state register.
- Printable byte (0x20–0x7E): write the character at (row, col), then advance col. If col was COLS-1: col←0 and do a newline.
- 0x0D (CR): col←0. No write.
- 0x0A (LF): newline. col is unchanged.
- 0x08 (BS): if col>0, col←col-1 and write 0x20 at the new position. At col 0: no write and no cursor change.
- 0x0C (FF): clear the whole screen, then set the cursor to (0,0).
- All other codes (0x00–0x1F not listed above, and 0x7F): accepted and dropped. No write, no cursor change.
- Newline: if row<ROWS-1, row←row+1. If row==ROWS-1, row←0 and enter CLR_ROW for row 0. There is no scrolling; the screen wraps and the new line is blanked.
- States:
  - IDLE: services bytes.
  - CLR_ROW: issues COLS writes of 0x20 at {row, 0..COLS-1}, one per cycle, then returns to IDLE.
  - CLR_SCR: issues writes of 0x20 for rows 0..ROWS-1 × cols 0..COLS-1, row-major, one per cycle (2400 writes), then returns to IDLE with the cursor at (0,0).
- A clear counter ({row, col} style, COL_BITS+ROW_BITS) steps col 0..COLS-1 and then increments row. Addresses outside the visible grid (col ≥ COLS) are never written.
- `busy` = state != IDLE.

## Timing
- Reset (async, rst_n low): state IDLE; `char_we`=0; `char_addr`=0; `char_value`=0; `cur_col`=0; `cur_row`=0; `busy`=0. `in_ready`=1 once reset is released.
- Write outputs are registered. A byte accepted at edge N produces `char_we`=1 with its address/value during cycle N+1, for exactly one cycle.
- Cursor registers update at the same edge N.
- For a printable byte at col COLS-1, row ROWS-1:
  - the character write occurs in cycle N+1;
  - state is CLR_ROW from edge N;
  - the first clear write occurs in cycle N+1 … conflict rule: the character write takes priority, so the clear writes occupy cycles N+2..N+COLS+1;
  - `in_ready` returns high in cycle N+COLS+2.
- LF/FF accepted at edge N: the first clear write is in cycle N+1. CLR_ROW lasts COLS cycles; CLR_SCR lasts COLS*ROWS cycles. `in_ready` is high in the cycle after the last clear write.
- Back-to-back bytes in IDLE: throughput of one byte per cycle.
- `in_valid` held while `in_ready`=0: the byte is held off and not dropped. `in_char` must stay stable until accepted.
- Reset mid-clear: the clear aborts immediately, the state returns to IDLE, and no further writes occur. Memory contents are left as-is.

## Structure
- Shared package `vga_text_pkg`: COLS/ROWS defaults; the ASCII constants (CR, LF, BS, FF, SPACE); the state enum {IDLE, CLR_ROW, CLR_SCR}; and a function packing {row, col} into the 12-bit address.
- One natural sub-module, `text_cursor`: holds the col/row registers and implements advance/newline/backspace/home with wrap detection, reporting `wrap_to_top` to the FSM.
- The FSM, clear counter and output registers stay in `vga_text_console`.

## Test plan
- Reset, then send 'A' (0x41): one write, addr 0x000, value 0x00000041. Cursor then (col 1, row 0); `in_ready` stays high.
- Send "Hi", CR, LF, "x":
  - writes 0x48 @0x000, 0x69 @0x001, 0x78 @0x080;
  - no writes for CR/LF;
  - cursor ends at (1,1).
- BS at col 0: no write and cursor unchanged. Then "ab", BS: third write is 0x20 @0x001 and cursor ends at (1,0).
- Move to row 29 and send LF:
  - cursor goes to (0,0);
  - 80 consecutive writes of 0x20 @0x000..0x04F;
  - `in_ready` is low for exactly 80 cycles;
  - a held `in_valid` byte is accepted afterwards.
- FF: 2400 writes of 0x20 covering rows 0–29 × cols 0–79 with no address having col ≥ 80. `busy` is high throughout; cursor ends at (0,0).
- Assert `rst_n` low halfway through an FF clear: `char_we` drops with no further writes after reset, all outputs are at reset values, and a following 'Z' writes 0x5A @0x000.
